// File: rtl/acc_forwarding_param.sv
// acc_forwarding_param
// Group-sum accumulate-and-forward stage. A signed local sum is accumulated
// over a programmable-length group of valid beats; when the group closes,
// every beat of that group still in the DEPTH-stage delay line is rewritten
// with the saturated group total.
//
// Handshake: there is no backpressure. A beat is accepted on every clock edge
// where i_en is high and rst is low; i_valid qualifies the beat. o_valid marks
// a real beat at the output and is meaningful on every cycle. i_en low freezes
// the whole block, including the outputs.
module acc_forwarding_param #(
    parameter int SUM_W = 16,
    parameter int DEPTH = 12,
    parameter int BYP_W = 1024,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic signed [SUM_W-1:0] i_loc_sum,
    input  logic [LEN_W-1:0]        i_group_len,
    input  logic                    i_last,
    input  logic [BYP_W-1:0]        i_byp,
    output logic                    o_valid,
    output logic signed [SUM_W-1:0] o_global_sum,
    output logic                    o_sat,
    output logic                    o_abort,
    output logic                    o_last,
    output logic [BYP_W-1:0]        o_byp
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    localparam logic signed [SUM_W-1:0] SUM_MAX = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};
    localparam logic [LEN_W-1:0]        LEN_MAX = LEN_W'(DEPTH);

    // Group control state
    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        w_cnt_nxt;
    logic [LEN_W-1:0]        r_len;
    logic [LEN_W-1:0]        w_len_nxt;
    logic signed [SUM_W-1:0] r_acc;
    logic signed [SUM_W-1:0] w_acc_nxt;
    logic                    r_sticky;
    logic                    w_sticky_nxt;

    // Front-end datapath
    logic [LEN_W-1:0]        w_len_clamp;
    logic [LEN_W-1:0]        w_len_eff;
    logic [LEN_W-1:0]        w_cnt_inc;
    logic signed [SUM_W-1:0] w_acc_in;
    logic [SUM_W:0]          w_wide;
    logic                    w_ovf;
    logic signed [SUM_W-1:0] w_front;
    logic                    w_grp_sat;
    logic                    w_end;
    logic                    w_grow;
    logic                    w_abort;

    // Delay line
    logic                    r_v     [DEPTH];
    logic signed [SUM_W-1:0] r_sum   [DEPTH];
    logic                    r_sat   [DEPTH];
    logic                    r_abort [DEPTH];
    logic                    r_last  [DEPTH];
    logic [BYP_W-1:0]        r_byp   [DEPTH];

    // Saturating front sum and group end/abort decode for the current beat
    always_comb begin
        w_len_clamp = (i_group_len > LEN_MAX) ? LEN_MAX : i_group_len;
        // The length is only sampled on the first beat; an open group uses the held copy
        w_len_eff   = (r_state == S_IDLE) ? w_len_clamp : r_len;
        w_acc_in    = (r_state == S_IDLE) ? '0 : r_acc;
        w_wide      = {w_acc_in[SUM_W-1], w_acc_in} + {i_loc_sum[SUM_W-1], i_loc_sum};
        w_ovf       = w_wide[SUM_W] ^ w_wide[SUM_W-1];
        if (w_ovf) begin
            w_front = w_wide[SUM_W] ? SUM_MIN : SUM_MAX;
        end else begin
            w_front = w_wide[SUM_W-1:0];
        end
        w_grp_sat = r_sticky | w_ovf;
        w_cnt_inc = r_cnt + LEN_W'(1);
        // Length 0 is pass-through: never ends, never grows, ignores i_last
        w_end     = i_valid && (w_len_eff != '0) && ((w_cnt_inc == w_len_eff) || i_last);
        w_grow    = i_valid && (w_len_eff != '0) && !w_end;
        w_abort   = !i_valid && (r_state == S_ACC);
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_len    <= '0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_len    <= w_len_nxt;
            r_acc    <= w_acc_nxt;
            r_sticky <= w_sticky_nxt;
        end
    end

    // Next-state logic: hold when disabled, close on end, clear on abort
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_len_nxt    = r_len;
        w_acc_nxt    = r_acc;
        w_sticky_nxt = r_sticky;
        if (i_en) begin
            if (w_end) begin
                // Closing clears everything so the next beat may open a new group
                w_state_nxt  = S_IDLE;
                w_cnt_nxt    = '0;
                w_acc_nxt    = '0;
                w_sticky_nxt = 1'b0;
            end else if (w_grow) begin
                w_state_nxt  = S_ACC;
                w_cnt_nxt    = w_cnt_inc;
                w_acc_nxt    = w_front;
                w_sticky_nxt = w_grp_sat;
                if (r_state == S_IDLE) begin
                    w_len_nxt = w_len_clamp;
                end
            end else if (w_abort) begin
                w_state_nxt  = S_IDLE;
                w_cnt_nxt    = '0;
                w_acc_nxt    = '0;
                w_sticky_nxt = 1'b0;
            end
        end
    end

    // Delay line shift with in-place rewrite of the closing or aborted group
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_v[k]     <= 1'b0;
                r_sum[k]   <= '0;
                r_sat[k]   <= 1'b0;
                r_abort[k] <= 1'b0;
                r_last[k]  <= 1'b0;
                r_byp[k]   <= '0;
            end
        end else if (i_en) begin
            r_v[0]     <= i_valid;
            r_sum[0]   <= i_loc_sum;
            r_sat[0]   <= 1'b0;
            r_abort[0] <= 1'b0;
            r_last[0]  <= 1'b0;
            r_byp[0]   <= i_byp;
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k]     <= r_v[k-1];
                r_sum[k]   <= r_sum[k-1];
                r_sat[k]   <= r_sat[k-1];
                r_abort[k] <= r_abort[k-1];
                r_last[k]  <= r_last[k-1];
                r_byp[k]   <= r_byp[k-1];
            end
            // Post-shift, the group occupies entries 0..cnt (current beat at 0)
            if (w_end) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (LEN_W'(k) <= r_cnt) begin
                        r_sum[k] <= w_front;
                        r_sat[k] <= w_grp_sat;
                    end
                end
                r_last[0] <= 1'b1;
            end
            // Pending beats land at entries 1..cnt; entry 0 is the gap beat
            if (w_abort) begin
                for (int k = 1; k < DEPTH; k++) begin
                    if (LEN_W'(k) <= r_cnt) begin
                        r_abort[k] <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_valid      = r_v[DEPTH-1];
    assign o_global_sum = r_sum[DEPTH-1];
    assign o_sat        = r_sat[DEPTH-1];
    assign o_abort      = r_abort[DEPTH-1];
    assign o_last       = r_last[DEPTH-1];
    assign o_byp        = r_byp[DEPTH-1];

endmodule

// File: tb/tb_acc_forwarding_param.sv
// Testbench for acc_forwarding_param (SUM_W=16, DEPTH=12).
// Directed beats push hand-computed expectations into a queue; a monitor
// pops one entry for every output beat produced by an enabled edge.
module tb_acc_forwarding_param;

    localparam int SUM_W = 16;
    localparam int DEPTH = 12;
    localparam int BYP_W = 1024;
    localparam int LEN_W = $clog2(DEPTH + 1);

    typedef struct {
        logic [SUM_W-1:0] sum;
        logic             sat;
        logic             abort;
        logic             last;
        logic [BYP_W-1:0] byp;
        int               t;
    } exp_t;

    logic                    clk;
    logic                    rst;
    logic                    i_en;
    logic                    i_valid;
    logic signed [SUM_W-1:0] i_loc_sum;
    logic [LEN_W-1:0]        i_group_len;
    logic                    i_last;
    logic [BYP_W-1:0]        i_byp;
    logic                    o_valid;
    logic signed [SUM_W-1:0] o_global_sum;
    logic                    o_sat;
    logic                    o_abort;
    logic                    o_last;
    logic [BYP_W-1:0]        o_byp;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   en_edges;
    logic last_edge_en;

    acc_forwarding_param #(
        .SUM_W(SUM_W),
        .DEPTH(DEPTH),
        .BYP_W(BYP_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .i_valid     (i_valid),
        .i_loc_sum   (i_loc_sum),
        .i_group_len (i_group_len),
        .i_last      (i_last),
        .i_byp       (i_byp),
        .o_valid     (o_valid),
        .o_global_sum(o_global_sum),
        .o_sat       (o_sat),
        .o_abort     (o_abort),
        .o_last      (o_last),
        .o_byp       (o_byp)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count enabled edges; output time stamps are checked against this
    always @(posedge clk) begin
        en_edges     <= en_edges + ((i_en && !rst) ? 1 : 0);
        last_edge_en <= i_en && !rst;
    end

    // Drive one beat and queue its expected output
    task automatic beat(input bit v, input int loc, input int len, input bit lst,
                        input int es, input bit esat, input bit eab, input bit elast);
        logic [BYP_W-1:0] b;
        exp_t e;
        for (int i = 0; i < BYP_W / 32; i++) b[i*32 +: 32] = $urandom();
        i_valid     = v;
        i_loc_sum   = SUM_W'(loc);
        i_group_len = LEN_W'(len);
        i_last      = lst;
        i_byp       = b;
        if (v) begin
            e.sum   = SUM_W'(es);
            e.sat   = esat;
            e.abort = eab;
            e.last  = elast;
            e.byp   = b;
            e.t     = en_edges + DEPTH;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stall(input int n);
        i_en    = 1'b0;
        i_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        i_en = 1'b1;
    endtask

    initial begin
        exp_t e;
        int   wait_cyc;
        n_cmp        = 0;
        n_bad        = 0;
        en_edges     = 0;
        last_edge_en = 1'b0;
        rst          = 1'b1;
        i_en         = 1'b1;
        i_valid      = 1'b0;
        i_loc_sum    = '0;
        i_group_len  = '0;
        i_last       = 1'b0;
        i_byp        = '0;

        // Monitor: one comparison per output beat from an enabled edge
        fork
            forever begin
                @(negedge clk);
                if (last_edge_en && o_valid) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL out_unexpected: got sum=%0d last=%0b abort=%0b at edge %0d, want no beat",
                                 o_global_sum, o_last, o_abort, en_edges);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_global_sum !== e.sum || o_sat !== e.sat || o_abort !== e.abort ||
                            o_last !== e.last || o_byp !== e.byp || en_edges != e.t) begin
                            n_bad++;
                            $display("FAIL out_beat: got sum=%0d sat=%0b abort=%0b last=%0b byp_ok=%0b edge=%0d, want sum=%0d sat=%0b abort=%0b last=%0b edge=%0d",
                                     o_global_sum, o_sat, o_abort, o_last, (o_byp === e.byp), en_edges,
                                     $signed(e.sum), e.sat, e.abort, e.last, e.t);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        n_cmp++;
        if ({o_valid, o_global_sum, o_sat, o_abort, o_last} !== '0 || o_byp !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%0b sum=%0d, want all zero", o_valid, o_global_sum);
        end

        // len=4 contiguous
        beat(1, 5, 4, 0, 26, 0, 0, 0);
        beat(1, 6, 4, 0, 26, 0, 0, 0);
        beat(1, 7, 4, 0, 26, 0, 0, 0);
        beat(1, 8, 4, 0, 26, 0, 0, 1);
        idle(2);
        // Back-to-back len=3 groups
        beat(1, 1, 3, 0, 6, 0, 0, 0);
        beat(1, 2, 3, 0, 6, 0, 0, 0);
        beat(1, 3, 3, 0, 6, 0, 0, 1);
        beat(1, 10, 3, 0, 60, 0, 0, 0);
        beat(1, 20, 3, 0, 60, 0, 0, 0);
        beat(1, 30, 3, 0, 60, 0, 0, 1);
        // Saturation, positive then negative, then clean group
        beat(1, 30000, 2, 0, 32767, 1, 0, 0);
        beat(1, 30000, 2, 0, 32767, 1, 0, 1);
        beat(1, -30000, 2, 0, -32768, 1, 0, 0);
        beat(1, -30000, 2, 0, -32768, 1, 0, 1);
        beat(1, 1, 2, 0, 2, 0, 0, 0);
        beat(1, 1, 2, 0, 2, 0, 0, 1);
        // Abort by gap
        beat(1, 5, 4, 0, 5, 0, 1, 0);
        beat(1, 6, 4, 0, 6, 0, 1, 0);
        idle(1);
        // Early close with i_last
        beat(1, 1, 8, 0, 6, 0, 0, 0);
        beat(1, 2, 8, 0, 6, 0, 0, 0);
        beat(1, 3, 8, 1, 6, 0, 0, 1);
        // i_last on the first beat, and len=1
        beat(1, 9, 4, 1, 9, 0, 0, 1);
        beat(1, -5, 1, 0, -5, 0, 0, 1);
        // Full-depth group, then the same with a 3-cycle enable stall
        for (int i = 1; i <= 12; i++) beat(1, i, 12, 0, 78, 0, 0, (i == 12));
        for (int i = 1; i <= 6; i++) beat(1, i, 12, 0, 78, 0, 0, 0);
        stall(3);
        for (int i = 7; i <= 12; i++) beat(1, i, 12, 0, 78, 0, 0, (i == 12));
        // Clamped length 15 behaves as 12
        for (int i = 1; i <= 12; i++) beat(1, 2, 15, 0, 24, 0, 0, (i == 12));
        idle(DEPTH + 2);

        // Reset in the middle of an open group
        beat(1, 9, 4, 0, 0, 0, 0, 0);
        beat(1, 9, 4, 0, 0, 0, 0, 0);
        exp_q.delete();
        rst     = 1'b1;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({o_valid, o_global_sum, o_sat, o_abort, o_last} !== '0 || o_byp !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_group: got valid=%0b sum=%0d, want all zero", o_valid, o_global_sum);
        end
        rst = 1'b0;
        beat(1, 4, 2, 0, 8, 0, 0, 0);
        beat(1, 4, 2, 0, 8, 0, 0, 1);
        // Pass-through, i_last ignored
        beat(1, 7, 0, 0, 7, 0, 0, 0);
        beat(1, -3, 0, 1, -3, 0, 0, 0);

        // Drain with a bounded wait
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 100) begin
            idle(1);
            wait_cyc++;
        end
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d beats still expected, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
